msg_dispatch: RTL and testbench
===============================

Name: msg_dispatch

Overview:
Downstream consumer of the serial message detector. Takes each decoded frame (4-bit payload plus 2-bit destination, qualified by the detector's valid and error flags) and stores the payload in one of four per-destination FIFOs. A host reads the FIFOs through a simple request/response port. The block also keeps saturating counters of detector errors and of messages dropped because their FIFO was full.

Parameters:
DEPTH, 4, entries per destination FIFO; must be a power of 2, at least 2.
CNT_W, 8, width of err_cnt and drop_cnt.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
p_in  input  4  payload from detector
d_in  input  2  destination from detector
outva  input  1  detector output-valid; level, may stay high for several cycles
err_in  input  1  detector frame error; level
rd_en  input  1  read request for channel rd_ch
rd_ch  input  2  channel selected for read
dout  output  4  read payload, registered
dout_valid  output  1  one-cycle pulse; dout holds valid data
empty  output  4  per-channel empty flag
full  output  4  per-channel full flag
err_cnt  output  CNT_W  count of err_in rising edges, saturating
drop_cnt  output  CNT_W  count of messages dropped on full, saturating

Behaviour:
- Reset (rst=1 at a clock edge) clears the following; it takes priority over all other activity, including mid-write or mid-read:
  - all FIFO pointers and occupancy; empty=4'hF, full=0
  - dout=0, dout_valid=0, err_cnt=0, drop_cnt=0
  - the edge-detect registers outva_q and err_q, cleared to 0
- Edge detection:
  - wr_evt = outva & ~outva_q
  - err_evt = err_in & ~err_q
  - A held outva therefore produces exactly one event.
- Write:
  - On wr_evt with err_in=0: if the FIFO at d_in is not full, push p_in; otherwise drop the message and increment drop_cnt.
  - On wr_evt with err_in=1: the error wins. Discard the message and neither push nor count a drop.
  - p_in and d_in are sampled in the wr_evt cycle.
- Error count: on err_evt, increment err_cnt. Increment is independent of outva.
- Saturation: err_cnt and drop_cnt stop at all-ones and never wrap.
- Read:
  - Cycle N: rd_en=1 and empty[rd_ch]=0 pops the head entry.
  - Cycle N+1: dout=that entry, dout_valid=1.
  - A read of an empty channel is ignored: dout_valid=0 next cycle and dout holds its previous value.
  - dout holds its value until the next successful read.
- Simultaneous read and write, same channel:
  - Full before the edge: the pop frees a slot, the write is accepted, no drop, and full stays 1.
  - Empty before the edge: the read is ignored and the write is accepted.
  - Otherwise both take effect and occupancy is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked with a counter (0..DEPTH), which is the source of the full and empty flags.
- Flags are registered. They reflect state after the last clock edge, with no combinational path from inputs.
- Ordering: each channel is strictly FIFO. Channels are independent.

Decomposition:
- Shared package msg_pkg:
  - constants N_DEST=4, PAYLOAD_W=4, DEST_W=2
  - typedefs payload_t (logic [3:0]) and dest_t (logic [1:0])
  - the same package is reused by the detector and by future upstream serializers
- One sub-module, chan_fifo:
  - single-channel synchronous FIFO with push, pop, data in/out, full, empty
  - parameter DEPTH
  - instantiated N_DEST times through a generate loop
- The top level holds the edge detectors, the write/read demux, the output register and the counters.

Test Plan:
- Reset, then outva pulses with (d=2,p=4'hA) and (d=2,p=4'h5); read ch2 twice -> dout=A then 5, each with dout_valid=1 one cycle after rd_en; then empty[2]=1.
- Hold outva high for 5 cycles with d=1, p=3 -> exactly one entry in ch1 and drop_cnt=0.
- Write 5 messages to ch0 with DEPTH=4 -> full[0]=1 after the 4th, drop_cnt=1, and reads return entries 1-4 in order.
- With ch0 full, assert wr_evt (p=F) and rd_en on ch0 in the same cycle -> no drop, full[0] stays 1, and the last read-out entry is F.
- outva and err_in rise together -> no push, err_cnt=1, drop_cnt=0. Then 300 err_in pulses -> err_cnt=255.
- Assert rst mid-stream with 3 entries in ch3 and rd_en=1 -> next cycle empty=F, dout=0, dout_valid=0, counters 0.

Source files
------------

// File: rtl/msg_pkg.sv
// msg_pkg: shared constants and types for the serial message path.
// Used by the detector, the dispatcher and upstream serializers.
//   N_DEST    number of destination channels
//   PAYLOAD_W payload width in bits
//   DEST_W    destination field width in bits
package msg_pkg;

   localparam int unsigned N_DEST    = 4;
   localparam int unsigned PAYLOAD_W = 4;
   localparam int unsigned DEST_W    = 2;

   typedef logic [PAYLOAD_W-1:0] payload_t;
   typedef logic [DEST_W-1:0]    dest_t;

endpackage

// File: rtl/chan_fifo.sv
// chan_fifo: single-channel synchronous FIFO with registered full/empty flags.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push, din   write request and data; ignored when full unless popping
//   pop, dout   read request and head-of-queue data (dout valid when !empty)
//   full, empty registered occupancy flags
module chan_fifo
   import msg_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [PAYLOAD_W-1:0] din,
   output logic [PAYLOAD_W-1:0] dout,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]     count_q, count_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic                 do_push, do_pop;
   logic [PAYLOAD_W-1:0] mem_q [DEPTH];

   always_comb begin
      do_pop  = pop & ~empty_q;
      // A pop in the same cycle frees the slot a full FIFO needs.
      do_push = push & (~full_q | do_pop);

      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + OCC_W'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - OCC_W'(1);
      end

      full_d  = (count_d == OCC_W'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is not reset; pointers and occupancy define what is valid.
   // When full with a simultaneous pop, wr_ptr equals rd_ptr: the head is
   // read out combinationally before this edge overwrites it.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/msg_dispatch.sv
// msg_dispatch: routes decoded frames into per-destination FIFOs and serves
// host reads; counts detector errors and drops on full, both saturating.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   p_in, d_in         payload and destination, sampled on a rising outva
//   outva, err_in      detector valid / error levels (edge-detected here)
//   rd_en, rd_ch       host read request and channel
//   dout, dout_valid   registered read data and one-cycle valid pulse
//   empty, full        per-channel registered flags
//   err_cnt, drop_cnt  saturating event counters
module msg_dispatch
   import msg_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PAYLOAD_W-1:0] p_in,
   input  logic [DEST_W-1:0]    d_in,
   input  logic                 outva,
   input  logic                 err_in,
   input  logic                 rd_en,
   input  logic [DEST_W-1:0]    rd_ch,
   output logic [PAYLOAD_W-1:0] dout,
   output logic                 dout_valid,
   output logic [N_DEST-1:0]    empty,
   output logic [N_DEST-1:0]    full,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [CNT_W-1:0]     drop_cnt
);

   logic                 outva_q, outva_d;
   logic                 err_q, err_d;
   logic [PAYLOAD_W-1:0] dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d;
   logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

   logic                 wr_evt, err_evt, rd_ok, drop;
   logic [N_DEST-1:0]    push, pop;
   logic [PAYLOAD_W-1:0] head [N_DEST];

   for (genvar g = 0; g < N_DEST; g++) begin : g_chan
      chan_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   (p_in),
         .dout  (head[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   always_comb begin
      outva_d = outva;
      err_d   = err_in;
      wr_evt  = outva & ~outva_q;
      err_evt = err_in & ~err_q;

      rd_ok = rd_en & ~empty[rd_ch];
      pop   = '0;
      if (rd_ok) begin
         pop[rd_ch] = 1'b1;
      end

      // An error on the same cycle discards the frame outright.
      push = '0;
      drop = 1'b0;
      if (wr_evt && !err_in) begin
         if (!full[d_in] || pop[d_in]) begin
            push[d_in] = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      dout_d       = rd_ok ? head[rd_ch] : dout_q;
      dout_valid_d = rd_ok;

      err_cnt_d = err_cnt_q;
      if (err_evt && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end

      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outva_q      <= 1'b0;
         err_q        <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         err_cnt_q    <= '0;
         drop_cnt_q   <= '0;
      end else begin
         outva_q      <= outva_d;
         err_q        <= err_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         err_cnt_q    <= err_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign err_cnt    = err_cnt_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_msg_dispatch.sv
// tb_msg_dispatch: randomized and directed stimulus against a queue-based
// reference model; read data is checked by a scoreboard monitor.
module tb_msg_dispatch;
   import msg_pkg::*;

   localparam int DEPTH   = 4;
   localparam int CNT_MAX = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] p_in;
   logic [1:0] d_in;
   logic       outva, err_in, rd_en;
   logic [1:0] rd_ch;
   logic [3:0] dout;
   logic       dout_valid;
   logic [3:0] empty, full;
   logic [7:0] err_cnt, drop_cnt;

   always #5 clk = ~clk;

   msg_dispatch #(
      .DEPTH (DEPTH),
      .CNT_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .p_in       (p_in),
      .d_in       (d_in),
      .outva      (outva),
      .err_in     (err_in),
      .rd_en      (rd_en),
      .rd_ch      (rd_ch),
      .dout       (dout),
      .dout_valid (dout_valid),
      .empty      (empty),
      .full       (full),
      .err_cnt    (err_cnt),
      .drop_cnt   (drop_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model
   logic [3:0] m_fifo [4][$];
   logic [3:0] sb_q [$];
   int         m_err, m_drop;
   logic [3:0] m_dout;
   logic       m_valid, m_outva, m_errp;

   function automatic void cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Scoreboard monitor: every valid pulse must match the oldest expected read.
   always @(negedge clk) begin
      logic [3:0] e;
      if (dout_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            cmp("unexpected_dout_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            cmp("dout_data", int'(dout), int'(e));
         end
      end
   end

   task automatic step(input logic r, input logic ov, input logic er, input logic [3:0] p,
                       input logic [1:0] d, input logic re, input logic [1:0] rc);
      logic [3:0] exp_empty, exp_full;
      rst = r; outva = ov; err_in = er; p_in = p; d_in = d; rd_en = re; rd_ch = rc;
      m_valid = 1'b0;
      if (r) begin
         for (int c = 0; c < 4; c++) m_fifo[c].delete();
         m_err = 0; m_drop = 0; m_dout = '0; m_outva = 1'b0; m_errp = 1'b0;
      end else begin
         // Pop before push: a read frees the slot a same-cycle write may need.
         if (re && m_fifo[rc].size() > 0) begin
            m_dout  = m_fifo[rc].pop_front();
            m_valid = 1'b1;
            sb_q.push_back(m_dout);
         end
         if (ov && !m_outva && !er) begin
            if (m_fifo[d].size() < DEPTH) m_fifo[d].push_back(p);
            else if (m_drop < CNT_MAX) m_drop++;
         end
         if (er && !m_errp && m_err < CNT_MAX) m_err++;
         m_outva = ov;
         m_errp  = er;
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
         exp_empty[c] = (m_fifo[c].size() == 0);
         exp_full[c]  = (m_fifo[c].size() == DEPTH);
      end
      cmp("empty", int'(empty), int'(exp_empty));
      cmp("full", int'(full), int'(exp_full));
      cmp("err_cnt", int'(err_cnt), m_err);
      cmp("drop_cnt", int'(drop_cnt), m_drop);
      cmp("dout_hold", int'(dout), int'(m_dout));
      cmp("dout_valid", int'(dout_valid), int'(m_valid));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0);
   endtask

   task automatic wr(input logic [3:0] p, input logic [1:0] d);
      step(1'b0, 1'b1, 1'b0, p, d, 1'b0, 2'd0);
      idle();
   endtask

   task automatic rd(input logic [1:0] c);
      step(1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b1, c);
   endtask

   initial begin
      step(1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0);
      step(1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0);
      cmp("reset_empty", int'(empty), 15);

      // Two frames to ch2, read back in order.
      wr(4'hA, 2'd2);
      wr(4'h5, 2'd2);
      rd(2'd2);
      cmp("first_read", int'(dout), 10);
      rd(2'd2);
      cmp("second_read", int'(dout), 5);
      idle();
      cmp("ch2_empty", int'(empty[2]), 1);

      // Held outva yields a single entry.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'h3, 2'd1, 1'b0, 2'd0);
      idle();
      cmp("held_no_drop", int'(drop_cnt), 0);
      rd(2'd1);
      rd(2'd1);
      idle();

      // Overfill ch0.
      for (int i = 1; i <= 5; i++) begin
         wr(4'(i), 2'd0);
         if (i == 4) cmp("full0_after_4", int'(full[0]), 1);
      end
      cmp("one_drop", int'(drop_cnt), 1);
      for (int i = 0; i < 4; i++) rd(2'd0);
      idle();

      // Write and read a full ch0 on the same edge.
      for (int i = 6; i <= 9; i++) wr(4'(i), 2'd0);
      step(1'b0, 1'b1, 1'b0, 4'hF, 2'd0, 1'b1, 2'd0);
      cmp("full0_kept", int'(full[0]), 1);
      cmp("no_new_drop", int'(drop_cnt), 1);
      idle();
      for (int i = 0; i < 4; i++) rd(2'd0);
      cmp("last_is_F", int'(dout), 15);
      idle();

      // Error wins over a simultaneous write; then saturate err_cnt.
      step(1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 2'd0);
      step(1'b0, 1'b1, 1'b1, 4'hC, 2'd3, 1'b0, 2'd0);
      cmp("err_once", int'(err_cnt), 1);
      cmp("err_no_push", int'(empty[3]), 1);
      idle();
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b0, 1'b1, 4'h0, 2'd0, 1'b0, 2'd0);
         idle();
      end
      cmp("err_saturated", int'(err_cnt), 255);

      // Reset in the middle of traffic.
      for (int i = 0; i < 4; i++) wr(4'(i + 7), 2'd3);
      rd(2'd3);
      step(1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 1'b1, 2'd3);
      cmp("rst_empty", int'(empty), 15);
      cmp("rst_dout", int'(dout), 0);
      cmp("rst_valid", int'(dout_valid), 0);
      cmp("rst_err_cnt", int'(err_cnt), 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 499) == 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 19) == 0),
              4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 2) == 0),
              2'($urandom_range(0, 3)));
      end

      idle();
      idle();
      cmp("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
